// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, FSM encoding,
// flush patterns and the stall-mask helper.
package pipe_ctrl_pkg;

    localparam int NSTAGE = 5;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // WB is never flushed: the faulting instruction has already left MEM.
    localparam logic [NSTAGE-1:0] FLUSH_BR   = 5'b00011;
    localparam logic [NSTAGE-1:0] FLUSH_EXCP = 5'b01111;

    function automatic logic [NSTAGE-1:0] stall_upto(input int k);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i <= k) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the core stages (master) and the
// pipeline sequencer (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              br_valid_i;
    logic [31:0]       br_pc_i;
    logic              excp_valid_i;
    logic [31:0]       excp_pc_i;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              in_flush;
    logic              stall_timeout;
    logic [CNT_W-1:0]  perf_stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output br_valid_i, br_pc_i, excp_valid_i, excp_pc_i,
        input  stall, bubble, flush, redirect_valid, redirect_pc,
        input  in_flush, stall_timeout, perf_stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  br_valid_i, br_pc_i, excp_valid_i, excp_pc_i,
        output stall, bubble, flush, redirect_valid, redirect_pc,
        output in_flush, stall_timeout, perf_stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog (saturating run-length counter with sticky timeout flag)
// and free-running stall-cycle performance counter.
module pipe_ctrl_wdog #(
    parameter int WDOG_LIMIT = 1023,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    output logic             timeout_o,
    output logic [CNT_W-1:0] perf_o
);
    localparam int WD_W = ($clog2(WDOG_LIMIT + 1) > 10) ? $clog2(WDOG_LIMIT + 1) : 10;

    logic [WD_W-1:0]  cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] perf_q, perf_d;

    always_comb begin
        cnt_d  = '0;
        tmo_d  = tmo_q;
        perf_d = perf_q;
        if (stall_i) begin
            perf_d = perf_q + CNT_W'(1);
            cnt_d  = (cnt_q == WD_W'(WDOG_LIMIT)) ? cnt_q : cnt_q + WD_W'(1);
            // Flag rises on the same edge the count reaches the limit.
            if (cnt_q >= WD_W'(WDOG_LIMIT - 1)) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tmo_q  <= 1'b0;
            perf_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            perf_q <= perf_d;
        end
    end

    assign timeout_o = tmo_q;
    assign perf_o    = perf_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: stall/bubble decode, branch and
// exception redirects, timed post-exception flush, watchdog and perf counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int WDOG_LIMIT   = 1023,
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [NSTAGE-1:0] flush_q, flush_d;
    logic              rv_q, rv_d;
    logic [31:0]       rpc_q, rpc_d;
    logic [NSTAGE-1:0] stall, bubble;
    logic              excp_acc, br_acc;
    logic              perf_tmo;
    logic [CNT_W-1:0]  perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            flush_q <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flush_q <= flush_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
        end
    end

    // Next state plus the registered flush/redirect values for the next cycle.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        flush_d = '0;
        rv_d    = 1'b0;
        rpc_d   = rpc_q;
        case (state_q)
            ST_RUN: begin
                if (excp_acc) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
                    flush_d = FLUSH_EXCP;
                    rv_d    = 1'b1;
                    rpc_d   = bus.excp_pc_i;
                end else if (br_acc) begin
                    flush_d = FLUSH_BR;
                    rv_d    = 1'b1;
                    rpc_d   = bus.br_pc_i;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d  = fcnt_q + FC_W'(1);
                    flush_d = FLUSH_EXCP;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Same-cycle stall decode: the oldest requesting stage freezes itself and
    // everything younger, and injects a bubble into the stage just past it.
    always_comb begin
        stall    = '0;
        bubble   = '0;
        excp_acc = 1'b0;
        br_acc   = 1'b0;
        if (!rst && state_q == ST_RUN) begin
            if (bus.stallreq_mem) begin
                stall          = stall_upto(STG_MEM);
                bubble[STG_WB] = 1'b1;
            end else if (bus.stallreq_ex) begin
                stall           = stall_upto(STG_EX);
                bubble[STG_MEM] = 1'b1;
            end else if (bus.stallreq_id) begin
                stall          = stall_upto(STG_ID);
                bubble[STG_EX] = 1'b1;
            end
            excp_acc = bus.excp_valid_i && !bus.stallreq_mem;
            br_acc   = bus.br_valid_i && !stall[STG_EX] && !excp_acc;
        end
    end

    pipe_ctrl_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall[STG_IF]),
        .timeout_o (perf_tmo),
        .perf_o    (perf_cnt)
    );

    assign bus.stall             = stall;
    assign bus.bubble            = bubble;
    assign bus.flush             = flush_q;
    assign bus.redirect_valid    = rv_q;
    assign bus.redirect_pc       = rpc_q;
    assign bus.in_flush          = (state_q == ST_FLUSH);
    assign bus.stall_timeout     = perf_tmo;
    assign bus.perf_stall_cycles = perf_cnt;
endmodule
